// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the UART-driven ALU command sequencer:
// sequencer state encoding and default datapath widths.
package alu_ctrl_pkg;

    localparam int N_DATA     = 8;
    localparam int N_OPERANDS = 8;
    localparam int N_OP       = 6;
    localparam int TIMEOUT    = 50_000_000;
    localparam int TIMEOUT_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/alu_uart_sequencer_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// pulses o_expire in the cycle the count sits at TIMEOUT-1.
module rx_timeout_timer #(
    parameter int TIMEOUT = 50_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == CNT_W'(TIMEOUT - 1));
    // A clear in the same cycle (accepted byte) suppresses the pulse.
    assign o_expire   = i_enable & ~i_clear & w_at_limit;

    // Idle counter; saturates at the limit so it never wraps back to zero.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from the UART receiver, drives the ALU,
// and hands the captured result back to the UART transmitter.
module alu_uart_sequencer #(
    parameter int N_DATA     = alu_ctrl_pkg::N_DATA,
    parameter int N_OPERANDS = alu_ctrl_pkg::N_OPERANDS,
    parameter int N_OP       = alu_ctrl_pkg::N_OP,
    parameter int TIMEOUT    = alu_ctrl_pkg::TIMEOUT
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [N_DATA-1:0]     i_rx_data,
    input  logic                  i_rx_done,
    input  logic [N_OPERANDS-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [N_OPERANDS-1:0] o_alu_A,
    output logic [N_OPERANDS-1:0] o_alu_B,
    output logic [N_OP-1:0]       o_alu_Op,
    output logic [N_DATA-1:0]     o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_timeout_err,
    output logic                  o_rx_overrun
);

    import alu_ctrl_pkg::*;

    state_t r_state;
    state_t w_next;
    logic   w_collecting;
    logic   w_accept;
    logic   w_drop;
    logic   w_tmr_clear;
    logic   w_tmr_enable;
    logic   w_expire;
    logic   w_timeout_evt;

    logic [N_OPERANDS-1:0] r_alu_A;
    logic [N_OPERANDS-1:0] r_alu_B;
    logic [N_OP-1:0]       r_alu_Op;
    logic [N_DATA-1:0]     r_tx_data;
    logic                  r_tx_start;
    logic                  r_busy;
    logic                  r_timeout_err;
    logic                  r_rx_overrun;

    assign w_collecting = (r_state == GET_A) || (r_state == GET_B) || (r_state == GET_OP);
    assign w_accept     = i_rx_done && w_collecting;
    assign w_drop       = i_rx_done && !w_collecting;
    // Holding the timer clear throughout GET_A covers the "clear on entry" case.
    assign w_tmr_clear  = w_accept || (r_state == GET_A);
    assign w_tmr_enable = (r_state == GET_B) || (r_state == GET_OP);

    rx_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_enable),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a byte arriving with the timeout takes priority.
    always_comb begin
        w_next        = r_state;
        w_timeout_evt = 1'b0;
        case (r_state)
            GET_A: begin
                if (i_rx_done) begin
                    w_next = GET_B;
                end else begin
                    w_next = GET_A;
                end
            end
            GET_B, GET_OP: begin
                if (i_rx_done) begin
                    w_next = (r_state == GET_B) ? GET_OP : EXEC;
                end else if (w_expire) begin
                    w_next        = GET_A;
                    w_timeout_evt = 1'b1;
                end else begin
                    w_next = r_state;
                end
            end
            EXEC:    w_next = SEND;
            SEND:    w_next = WAIT_TX;
            WAIT_TX: begin
                if (i_tx_done) begin
                    w_next = GET_A;
                end else begin
                    w_next = WAIT_TX;
                end
            end
            default: w_next = GET_A;
        endcase
    end

    // Operand/opcode/result capture and registered status outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_alu_A       <= '0;
            r_alu_B       <= '0;
            r_alu_Op      <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else begin
            if (w_accept && (r_state == GET_A)) begin
                r_alu_A <= i_rx_data[N_OPERANDS-1:0];
            end
            if (w_accept && (r_state == GET_B)) begin
                r_alu_B <= i_rx_data[N_OPERANDS-1:0];
            end
            if (w_accept && (r_state == GET_OP)) begin
                r_alu_Op <= i_rx_data[N_OP-1:0];
            end
            if (r_state == EXEC) begin
                r_tx_data <= N_DATA'(i_alu_result);
            end
            if (w_accept && (r_state == GET_A)) begin
                r_rx_overrun <= 1'b0;
            end else if (w_drop) begin
                r_rx_overrun <= 1'b1;
            end
            r_tx_start    <= (w_next == SEND);
            r_busy        <= (w_next != GET_A);
            r_timeout_err <= w_timeout_evt;
        end
    end

    assign o_alu_A       = r_alu_A;
    assign o_alu_B       = r_alu_B;
    assign o_alu_Op      = r_alu_Op;
    assign o_tx_data     = r_tx_data;
    assign o_tx_start    = r_tx_start;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;
    assign o_rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed plus randomized bench for alu_uart_sequencer with a behavioural
// ALU and a transaction-level expectation model; TIMEOUT is 20 cycles.
module tb_alu_uart_sequencer;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic [5:0] alu_Op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       timeout_err;
    logic       rx_overrun;

    int n_chk  = 0;
    int n_fail = 0;

    alu_uart_sequencer #(
        .N_DATA     (8),
        .N_OPERANDS (8),
        .N_OP       (6),
        .TIMEOUT    (TMO)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_rx_data     (rx_data),
        .i_rx_done     (rx_done),
        .i_alu_result  (alu_result),
        .i_tx_done     (tx_done),
        .o_alu_A       (alu_A),
        .o_alu_B       (alu_B),
        .o_alu_Op      (alu_Op),
        .o_tx_data     (tx_data),
        .o_tx_start    (tx_start),
        .o_busy        (busy),
        .o_timeout_err (timeout_err),
        .o_rx_overrun  (rx_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_A, alu_B, alu_Op);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command with gap idle cycles between bytes, checked end to end.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap);
        logic [5:0] op6;
        op6 = op[5:0];
        send_byte(a);
        chk("A_load", {24'h0, alu_A}, {24'h0, a});
        chk("ovr_clr_on_A", {31'h0, rx_overrun}, 32'h0);
        idle(gap);
        send_byte(b);
        chk("B_load", {24'h0, alu_B}, {24'h0, b});
        idle(gap);
        send_byte(op);
        chk("Op_load", {26'h0, alu_Op}, {26'h0, op6});
        chk("start_c1", {31'h0, tx_start}, 32'h0);
        step();
        chk("start_c2", {31'h0, tx_start}, 32'h1);
        chk("tx_data", {24'h0, tx_data}, {24'h0, alu_ref(a, b, op6)});
        step();
        chk("start_c3", {31'h0, tx_start}, 32'h0);
        chk("busy_wait", {31'h0, busy}, 32'h1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("busy_done", {31'h0, busy}, 32'h0);
        chk("no_tmo", {31'h0, timeout_err}, 32'h0);
    endtask

    initial begin
        int          pulses;
        int          first_at;
        logic [7:0]  ops [8];
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [7:0]  rop;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

        // Reset state
        idle(2);
        chk("rst_outputs", {alu_A, alu_B, 2'b00, alu_Op, tx_data},  32'h0);
        chk("rst_flags", {28'h0, tx_start, busy, timeout_err, rx_overrun}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic ADD command
        run_cmd(8'h05, 8'h03, 8'h20, 0);
        chk("basic_result", {24'h0, tx_data}, 32'h08);

        // Timeout after A and B, then a following command still works
        send_byte(8'h0A);
        send_byte(8'h02);
        pulses   = 0;
        first_at = -1;
        for (int i = 1; i <= TMO + 5; i++) begin
            step();
            if (timeout_err) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("tmo_pulses", pulses, 1);
        chk("tmo_cycle", first_at, TMO);
        chk("tmo_idle", {31'h0, busy}, 32'h0);
        chk("tmo_held_A", {24'h0, alu_A}, 32'h0A);
        run_cmd(8'h01, 8'h01, 8'h22, 0);
        chk("sub_zero", {24'h0, tx_data}, 32'h00);

        // Opcode byte lands exactly in the last idle cycle before timeout
        send_byte(8'h06);
        send_byte(8'h07);
        idle(TMO - 1);
        chk("bnd_busy", {31'h0, busy}, 32'h1);
        send_byte(8'h26);
        chk("bnd_no_err", {31'h0, timeout_err}, 32'h0);
        chk("bnd_op", {26'h0, alu_Op}, 32'h26);
        step();
        chk("bnd_start", {31'h0, tx_start}, 32'h1);
        chk("bnd_data", {24'h0, tx_data}, 32'h01);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("bnd_done", {31'h0, busy}, 32'h0);

        // Overrun during WAIT_TX and in the same cycle as tx_done
        send_byte(8'h40);
        send_byte(8'h02);
        send_byte(8'h20);
        idle(2);
        send_byte(8'hFF);
        chk("ovr_set", {31'h0, rx_overrun}, 32'h1);
        chk("ovr_A_kept", {24'h0, alu_A}, 32'h40);
        chk("ovr_data_kept", {24'h0, tx_data}, 32'h42);
        chk("ovr_busy", {31'h0, busy}, 32'h1);
        rx_data = 8'hFF;
        rx_done = 1'b1;
        tx_done = 1'b1;
        step();
        rx_done = 1'b0;
        tx_done = 1'b0;
        chk("ovr_same_idle", {31'h0, busy}, 32'h0);
        chk("ovr_same_flag", {31'h0, rx_overrun}, 32'h1);
        chk("ovr_same_A", {24'h0, alu_A}, 32'h40);
        send_byte(8'h09);
        chk("ovr_clear", {31'h0, rx_overrun}, 32'h0);
        chk("ovr_newA", {24'h0, alu_A}, 32'h09);
        send_byte(8'h01);
        send_byte(8'h20);
        idle(2);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;

        // Asynchronous reset after byte B
        send_byte(8'h11);
        send_byte(8'h22);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_data", {alu_A, alu_B, 2'b00, alu_Op, tx_data}, 32'h0);
        chk("arst_flags", {28'h0, tx_start, busy, timeout_err, rx_overrun}, 32'h0);
        step();
        rst = 1'b0;
        step();
        send_byte(8'h33);
        chk("arst_nextA", {24'h0, alu_A}, 32'h33);
        chk("arst_B_zero", {24'h0, alu_B}, 32'h00);
        chk("arst_busy", {31'h0, busy}, 32'h1);
        send_byte(8'h01);
        send_byte(8'h20);
        chk("arst_no_start", {31'h0, tx_start}, 32'h0);
        idle(2);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;

        // Width handling: opcode truncation and full-width result
        run_cmd(8'h02, 8'h03, 8'hC7, 0);
        chk("trunc_op", {26'h0, alu_Op}, 32'h07);
        run_cmd(8'h80, 8'h0F, 8'h25, 0);
        chk("wide_result", {24'h0, tx_data}, 32'h8F);

        // Randomized commands with random inter-byte gaps below the timeout
        for (int k = 0; k < 10; k++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = (k % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            rop = ops[$urandom_range(0, 7)];
            run_cmd(ra, rb, rop, int'($urandom_range(0, TMO - 1)));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
